// File: rtl/uart_pkg.sv
// Shared UART definitions: frame states, the bit-timing helper and the data width.
// Used by uart_receiver; the state encodings match the transmitter.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    Idle     = 3'd0,
    StartBit = 3'd1,
    DataBit  = 3'd2,
    StopBit  = 3'd3,
    Recover  = 3'd4
  } uart_state_t;

  // Clocks per bit; the +1 keeps receiver timing identical to the transmitter.
  function automatic logic [31:0] bit_cycles(input logic [31:0] frequency,
                                             input logic [31:0] speed);
    return frequency / speed + 32'd1;
  endfunction

endpackage

// File: rtl/uart_receiver_bit_sync.sv
// Two-flop synchronizer for a single asynchronous input.
// RESET_VALUE should match the input's idle level so reset creates no false edge.
module bit_sync #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic CLK_i,
  input  logic Reset_i,
  input  logic data,
  output logic synced
);

  logic meta;

  always_ff @(posedge CLK_i or posedge Reset_i) begin
    if (Reset_i) begin
      meta   <= RESET_VALUE;
      synced <= RESET_VALUE;
    end else begin
      meta   <= data;
      synced <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, LSB first, with a valid/ack output handshake and framing/overrun flags.
// Define RX_MAJORITY_VOTE_EN to take a 2-of-3 vote around each sample point (adds 1 clock of latency).
module uart_receiver
  import uart_pkg::*;
#(
  parameter logic [31:0] FREQUENCY = 32'd50_000_000,
  parameter logic [31:0] SPEED     = 32'd1_500_000
) (
  input  logic                 CLK_i,
  input  logic                 Reset_i,
  input  logic                 Rx,
  output logic [DATA_BITS-1:0] dataOut,
  output logic                 dataValid,
  input  logic                 dataAck,
  output logic                 frameError,
  output logic                 overrun
);

  localparam logic [31:0] BIT_CYCLES  = bit_cycles(FREQUENCY, SPEED);
  localparam logic [31:0] HALF_CYCLES = BIT_CYCLES / 32'd2;
  localparam logic [31:0] BIT_LAST    = BIT_CYCLES - 32'd1;
  localparam logic [3:0]  LAST_BIT    = 4'(DATA_BITS - 1);

  logic                 rxS;
  logic                 sampleBit;
  uart_state_t          state;
  logic [31:0]          tickCount;
  logic [3:0]           bitCount;
  logic [DATA_BITS-1:0] shift;

  bit_sync #(.RESET_VALUE(1'b1)) u_rx_sync (
    .CLK_i  (CLK_i),
    .Reset_i(Reset_i),
    .data   (Rx),
    .synced (rxS)
  );

`ifdef RX_MAJORITY_VOTE_EN
  // Deciding one tick late lets the window {N-1, N, N+1} sit around the nominal sample point.
  localparam logic [31:0] START_TICK = HALF_CYCLES;

  logic [1:0] rxHist;
  logic [2:0] voteWindow;

  always_ff @(posedge CLK_i or posedge Reset_i) begin
    if (Reset_i) begin
      rxHist <= 2'b11;
    end else begin
      rxHist <= {rxHist[0], rxS};
    end
  end

  assign voteWindow = {rxHist, rxS};
  assign sampleBit  = (voteWindow[0] & voteWindow[1]) |
                      (voteWindow[0] & voteWindow[2]) |
                      (voteWindow[1] & voteWindow[2]);
`else
  localparam logic [31:0] START_TICK = HALF_CYCLES - 32'd1;

  assign sampleBit = rxS;
`endif

  always_ff @(posedge CLK_i or posedge Reset_i) begin
    if (Reset_i) begin
      state      <= Idle;
      tickCount  <= '0;
      bitCount   <= '0;
      shift      <= '0;
      dataOut    <= '0;
      dataValid  <= 1'b0;
      frameError <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frameError <= 1'b0;

      if (dataAck && dataValid) begin
        dataValid <= 1'b0;
        overrun   <= 1'b0;
      end

      case (state)
        Idle: begin
          if (!rxS) begin
            tickCount <= '0;
            state     <= StartBit;
          end
        end

        StartBit: begin
          if (tickCount == START_TICK) begin
            tickCount <= '0;
            if (!sampleBit) begin
              bitCount <= '0;
              state    <= DataBit;
            end else begin
              state <= Idle;
            end
          end else begin
            tickCount <= tickCount + 32'd1;
          end
        end

        DataBit: begin
          if (tickCount == BIT_LAST) begin
            tickCount <= '0;
            shift     <= {sampleBit, shift[DATA_BITS-1:1]};
            bitCount  <= bitCount + 4'd1;
            if (bitCount == LAST_BIT) begin
              state <= StopBit;
            end
          end else begin
            tickCount <= tickCount + 32'd1;
          end
        end

        // A load in the same cycle as an ack replaces the pending byte without an overrun.
        StopBit: begin
          if (tickCount == BIT_LAST) begin
            tickCount <= '0;
            if (sampleBit) begin
              if (!dataValid || dataAck) begin
                dataOut   <= shift;
                dataValid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
              state <= Idle;
            end else begin
              frameError <= 1'b1;
              state      <= Recover;
            end
          end else begin
            tickCount <= tickCount + 32'd1;
          end
        end

        // Hold off until the line is idle so a break is not seen as a string of start bits.
        Recover: begin
          if (rxS) begin
            state <= Idle;
          end
        end

        default: begin
          state <= Idle;
        end
      endcase
    end
  end

endmodule
